// File: rtl/line_clear_if.sv
// line_clear_if: lock/clear request bus and playfield status of the line clear engine
// master drives lock_valid, pieceSqs, clear_board; slave returns lock_ready, backGround,
// busy, done, linesCleared, score, gameOver
interface line_clear_if #(parameter int ROWS = 12, parameter int COLS = 12, parameter int SCORE_W = 16);
  localparam int N = ROWS * COLS;
  logic lock_valid;
  logic lock_ready;
  logic [N-1:0] pieceSqs;
  logic clear_board;
  logic [N-1:0] backGround;
  logic busy;
  logic done;
  logic [3:0] linesCleared;
  logic [SCORE_W-1:0] score;
  logic gameOver;
  modport master (
    output lock_valid, pieceSqs, clear_board,
    input lock_ready, backGround, busy, done, linesCleared, score, gameOver
  );
  modport slave (
    input lock_valid, pieceSqs, clear_board,
    output lock_ready, backGround, busy, done, linesCleared, score, gameOver
  );
endinterface

// File: rtl/line_clear_engine.sv
// line_clear_engine: merges a landed piece into the playfield, clears full rows bottom-up, scores
// clock/reset: rising-edge clock, synchronous active-high reset
// bus (slave): lock handshake + pieceSqs + clear_board in; backGround, busy, done,
//              linesCleared, score, gameOver out
module line_clear_engine #(
  parameter int ROWS = 12,
  parameter int COLS = 12,
  parameter int SCORE_W = 16
) (
  input logic clock,
  input logic reset,
  line_clear_if.slave bus
);
  localparam int N = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  typedef enum logic [1:0] {IDLE, MERGE, SCAN, DONE} state_t;
  state_t state;
  logic [N-1:0] bg, piece, shiftMask, shifted;
  logic [RW-1:0] rowPtr;
  logic [3:0] lines;
  logic [SCORE_W-1:0] score, scoreInc;
  logic done, gameOver, rowFull, accept;
  assign bus.lock_ready = state == IDLE && !gameOver && !reset;
  assign accept = bus.lock_valid && bus.lock_ready;
  assign rowFull = &bg[rowPtr*COLS +: COLS];
  // rows 0..rowPtr drop by one row (row 0 fills with zeros), rows below rowPtr are kept
  assign shiftMask = {N{1'b1}} >> ((ROWS - 1 - int'(rowPtr)) * COLS);
  assign shifted = (shiftMask & (bg << COLS)) | (~shiftMask & bg);
  assign scoreInc = SCORE_W'(lines == 4'd0 ? 0 : lines == 4'd1 ? 1 : lines == 4'd2 ? 3 : lines == 4'd3 ? 5 : 8);
  assign bus.backGround = bg;
  assign bus.busy = state != IDLE;
  assign bus.done = done;
  assign bus.linesCleared = lines;
  assign bus.score = score;
  assign bus.gameOver = gameOver;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bg <= '0;
      piece <= '0;
      rowPtr <= RW'(ROWS - 1);
      lines <= '0;
      score <= '0;
      done <= 1'b0;
      gameOver <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            piece <= bus.pieceSqs;
            lines <= '0;
            state <= MERGE;
          end else if (bus.clear_board) begin
            bg <= '0;
            score <= '0;
            gameOver <= 1'b0;
            lines <= '0;
          end
        MERGE: begin
          bg <= bg | piece;
          gameOver <= gameOver | (|(bg & piece));
          rowPtr <= RW'(ROWS - 1);
          state <= SCAN;
        end
        SCAN:
          // a cleared row keeps rowPtr so the row that dropped into it is rechecked
          if (rowFull) begin
            bg <= shifted;
            lines <= lines + 4'd1;
          end else if (rowPtr == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            rowPtr <= rowPtr - RW'(1);
          end
        DONE: begin
          score <= score + scoreInc;
          gameOver <= gameOver | (|bg[COLS-1:0]);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_clear_engine.sv
// tb_line_clear_engine: directed and random locks checked against a row-compaction model
module tb_line_clear_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  line_clear_if bus ();
  line_clear_engine dut (.clock(clk), .reset(rst), .bus(bus));
  int nCompared = 0;
  int nMismatched = 0;
  logic [143:0] mBoard;
  logic [15:0] mScore;
  logic mOver;
  int tbl[5] = '{0, 1, 3, 5, 8};
  task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [143:0] bitsOf(input int lo, input int hi);
    logic [143:0] v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction
  function automatic logic [143:0] rnd144();
    return 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction
  task automatic doLock(input logic [143:0] p, input bit withClear);
    int k = 0;
    int dst = 11;
    int lat = 0;
    logic [143:0] nb = '0;
    logic [11:0] row;
    logic coll;
    coll = |(mBoard & p);
    mBoard = mBoard | p;
    for (int r = 11; r >= 0; r--) begin
      row = mBoard[r*12 +: 12];
      if (&row) k++;
      else begin
        nb[dst*12 +: 12] = row;
        dst--;
      end
    end
    @(negedge clk);
    check("lockReady", 144'(bus.lock_ready), 144'(1));
    bus.lock_valid = 1'b1;
    bus.pieceSqs = p;
    bus.clear_board = withClear;
    @(posedge clk);
    #1;
    bus.lock_valid = 1'b0;
    bus.clear_board = 1'b0;
    bus.pieceSqs = rnd144();
    check("busy", 144'(bus.busy), 144'(1));
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) lat = n;
    end
    check("latency", 144'(lat), 144'(13 + k));
    check("board", bus.backGround, nb);
    check("lines", 144'(bus.linesCleared), 144'(k));
    check("overMerge", 144'(bus.gameOver), 144'(mOver | coll));
    mBoard = nb;
    mOver = mOver | coll | (|nb[11:0]);
    mScore = mScore + 16'(tbl[k > 4 ? 4 : k]);
    @(posedge clk);
    #1;
    check("doneLow", 144'(bus.done), 144'(0));
    check("score", 144'(bus.score), 144'(mScore));
    check("gameOver", 144'(bus.gameOver), 144'(mOver));
    check("readyAfter", 144'(bus.lock_ready), 144'(!mOver));
  endtask
  task automatic clearBoard();
    @(negedge clk);
    bus.clear_board = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_board = 1'b0;
    mBoard = '0;
    mScore = '0;
    mOver = 1'b0;
    check("clrBoard", bus.backGround, 144'(0));
    check("clrScore", 144'(bus.score), 144'(0));
    check("clrOver", 144'(bus.gameOver), 144'(0));
    check("clrLines", 144'(bus.linesCleared), 144'(0));
    check("clrReady", 144'(bus.lock_ready), 144'(1));
  endtask
  initial begin
    logic [143:0] p;
    logic [11:0] row;
    int sel;
    bus.lock_valid = 1'b0;
    bus.pieceSqs = '0;
    bus.clear_board = 1'b0;
    mBoard = '0;
    mScore = '0;
    mOver = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstBoard", bus.backGround, 144'(0));
    check("rstScore", 144'(bus.score), 144'(0));
    check("rstDone", 144'(bus.done), 144'(0));
    check("rstOver", 144'(bus.gameOver), 144'(0));
    check("rstLines", 144'(bus.linesCleared), 144'(0));
    check("rstBusy", 144'(bus.busy), 144'(0));
    check("rstReady", 144'(bus.lock_ready), 144'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("readyOut", 144'(bus.lock_ready), 144'(1));
    doLock(bitsOf(132, 135), 1'b0);
    doLock(bitsOf(136, 139) | bitsOf(120, 120), 1'b0);
    doLock(bitsOf(140, 143), 1'b0);
    clearBoard();
    p = '0;
    for (int r = 8; r <= 11; r++) p = p | bitsOf(r * 12, r * 12 + 10);
    doLock(p, 1'b0);
    doLock(bitsOf(107, 107) | bitsOf(119, 119) | bitsOf(131, 131) | bitsOf(143, 143), 1'b0);
    doLock(bitsOf(132, 142) | bitsOf(108, 118) | bitsOf(120, 120), 1'b0);
    doLock(bitsOf(143, 143) | bitsOf(119, 119), 1'b1);
    doLock(bitsOf(132, 133), 1'b0);
    @(negedge clk);
    bus.lock_valid = 1'b1;
    bus.pieceSqs = bitsOf(5, 5);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("ignoredLock", 144'(bus.busy), 144'(0));
    end
    bus.lock_valid = 1'b0;
    check("ignoredBoard", bus.backGround, mBoard);
    clearBoard();
    repeat (30) begin
      if (mOver) clearBoard();
      p = '0;
      for (int r = 0; r < 12; r++) begin
        sel = $urandom_range(0, 9);
        row = mBoard[r*12 +: 12];
        if (sel < 2) p[r*12 +: 12] = ~row;
        else if (sel < 4) p[r*12 +: 12] = 12'($urandom) & ~row;
      end
      if ($urandom_range(0, 9) == 0) p = p | mBoard;
      doLock(p, $urandom_range(0, 3) == 0);
    end
    if (mOver) clearBoard();
    @(negedge clk);
    bus.lock_valid = 1'b1;
    bus.pieceSqs = bitsOf(96, 143);
    @(posedge clk);
    #1;
    bus.lock_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midBoard", bus.backGround, 144'(0));
    check("midScore", 144'(bus.score), 144'(0));
    check("midDone", 144'(bus.done), 144'(0));
    check("midReady", 144'(bus.lock_ready), 144'(0));
    @(negedge clk);
    rst = 1'b0;
    mBoard = '0;
    mScore = '0;
    mOver = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("postDone", 144'(bus.done), 144'(0));
      check("postReady", 144'(bus.lock_ready), 144'(1));
    end
    doLock(bitsOf(0, 11) | bitsOf(140, 141), 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
